reg_file: RTL

- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU and drives its A and B operands.
- The ALU registers its operands on posedge clk, so both read ports here are combinational.
- Also provides a synchronous write port, a hardwired-zero register 0, optional write-to-read bypass, a debug read port, and a post-reset clear sweep. The sweep exists because the storage maps to distributed RAM and cannot be reset in parallel.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/rf_read_mux.sv | 37 +++
 rtl/reg_file.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the hardwired-zero register index and
// the register-file state encoding that the control unit will also gate on.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_read_mux.sv
// One read port of the register file: forces r0 and not-yet-cleared contents to
// zero and, when enabled, forwards the write data of a same-cycle write.
module rf_read_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] data
);

    logic is_zero_reg;
    logic hit;

    assign is_zero_reg = (addr == ADDR_W'(REG_ZERO));
    // addr != 0 already guarantees wa != 0 on a hit, so r0 writes never forward.
    assign hit         = (BYPASS != 0) && we && (addr == wa);

    always_comb begin
        data = '0;
        if (ready && !is_zero_reg) begin
            if (hit) begin
                data = wd;
            end else begin
                data = stored;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file with two combinational ALU read ports, a debug port and a
// post-reset sweep that zeroes the distributed-RAM storage one entry per cycle.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              ready,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NPORT = 3;

    logic [DATA_W-1:0] mem [DEPTH];

    rf_state_e         state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              ready_reg;
    logic              wr_drop_reg;
    logic              last_clear;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Entry 0 is never read back, so the sweep starts at 1 and ends at the top entry.
    assign last_clear = (clr_ptr_reg == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= RF_CLEAR;
            clr_ptr_reg <= ADDR_W'(1);
            ready_reg   <= 1'b0;
            wr_drop_reg <= 1'b0;
        end else begin
            case (state_reg)
                RF_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                    wr_drop_reg <= we;
                    if (last_clear) begin
                        state_reg <= RF_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RF_RUN: begin
                    wr_drop_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= RF_CLEAR;
                    clr_ptr_reg <= ADDR_W'(1);
                    ready_reg   <= 1'b0;
                    wr_drop_reg <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the sweep and the CPU so the array maps to one RAM.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_ptr_reg;
        mem_wd = '0;
        if (rst_n) begin
            if (state_reg == RF_CLEAR) begin
                mem_we = 1'b1;
            end else if (state_reg == RF_RUN && we && wa != ADDR_W'(REG_ZERO)) begin
                mem_we = 1'b1;
                mem_wa = wa;
                mem_wd = wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    logic [ADDR_W-1:0] port_addr [NPORT];
    logic [DATA_W-1:0] port_data [NPORT];

    assign port_addr[0] = ra1;
    assign port_addr[1] = ra2;
    assign port_addr[2] = dbg_addr;

    // The debug port (index 2) always shows stored contents, never forwarded data.
    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_rport
            rf_read_mux #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .BYPASS ((gi < 2) ? BYPASS : 0)
            ) u_mux (
                .addr   (port_addr[gi]),
                .stored (mem[port_addr[gi]]),
                .ready  (ready_reg),
                .we     (we),
                .wa     (wa),
                .wd     (wd),
                .data   (port_data[gi])
            );
        end
    endgenerate

    assign rd1      = port_data[0];
    assign rd2      = port_data[1];
    assign dbg_data = port_data[2];
    assign ready    = ready_reg;
    assign wr_drop  = wr_drop_reg;

endmodule
